// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: datapath width and the operand sequencer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // Encoding 2'b11 is unused and recovers to ST_WAIT_A.
  typedef enum logic [1:0] {
    ST_WAIT_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_ISSUE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand bundle interface.
// Input side: serial word stream with valid/ready.
// Output side: the mux operand bundle with valid/ready.
interface alu_operand_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic [WIDTH-1:0] mux_in1;
  logic [WIDTH-1:0] mux_in2;
  logic             mux_sel;
  logic             out_valid;
  logic             out_ready;

  // Source of operand words and sink of bundles.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, mux_in1, mux_in2, mux_sel, out_valid
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, mux_in1, mux_in2, mux_sel, out_valid
  );

endinterface

// File: rtl/alu_operand_sequencer_wrap_counter.sv
// Free-running wrap-around enable counter with synchronous active-high reset.
module wrap_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count enabled events, wrapping modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Gathers operand A, operand B and the select bit from one shared input bus
// and presents them to the 2:1 operand mux as a single stable bundle.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  alu_operand_sequencer_if.slave bus,
  output logic [CNT_W-1:0]       issue_cnt
);

  seq_state_t       state;
  logic [WIDTH-1:0] mux_in1_q;
  logic [WIDTH-1:0] mux_in2_q;
  logic             mux_sel_q;
  logic             out_valid_q;
  logic             in_ready_d;
  logic             issue_fire;

  // Input acceptance decodes the state register only; out_ready never reaches in_ready.
  always_comb begin
    in_ready_d = (state == ST_WAIT_A) || (state == ST_WAIT_B);
  end

  // A handshake on the output side that flush does not cancel.
  always_comb begin
    issue_fire = (state == ST_ISSUE) && out_valid_q && bus.out_ready && !flush;
  end

  // Sequencer FSM with the bundle registers; flush aborts but keeps the last bundle data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT_A;
      mux_in1_q   <= '0;
      mux_in2_q   <= '0;
      mux_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= ST_WAIT_A;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_A: begin
          if (bus.in_valid) begin
            mux_in1_q <= bus.in_data;
            state     <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bus.in_valid) begin
            mux_in2_q   <= bus.in_data;
            mux_sel_q   <= bus.in_sel;
            out_valid_q <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_WAIT_A;
          end
        end
        default: begin
          state       <= ST_WAIT_A;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  wrap_counter #(
    .CNT_W (CNT_W)
  ) u_issue_cnt (
    .clk (clk),
    .rst (reset),
    .en  (issue_fire),
    .cnt (issue_cnt)
  );

  assign bus.in_ready  = in_ready_d;
  assign bus.mux_in1   = mux_in1_q;
  assign bus.mux_in2   = mux_in2_q;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule
